// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size codes, FSM encoding and latency counter width for the SRAM-like responder
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/byte_en_gen.sv
// rtl/byte_en_gen.sv - byte-lane enables and alignment check for a sized access
module byte_en_gen
    import mem_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] be,
    output logic       misalign
);

    always_comb begin
        be       = 4'b0000;
        misalign = 1'b0;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            SIZE_WORD: begin
                be       = 4'b1111;
                misalign = |addr_lo;
            end
            default:   misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/sram_like_resp.sv
// rtl/sram_like_resp.sv - single-outstanding SRAM-like responder with programmable latency over a local word RAM
module sram_like_resp
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int                 DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(LATENCY - 1);

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q;
    idx_t             idx_q;
    logic [3:0]       be_q;
    logic             err_flag_q;
    logic [31:0]      wdata_q;
    logic             data_ok_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic [31:0] ram [DEPTH];

    logic        accept;
    logic        commit;
    logic [3:0]  req_be;
    logic        req_misalign;
    idx_t        req_idx;
    logic        ld_wr;
    logic        ld_err;
    idx_t        ld_idx;
    logic [31:0] fwd_word;
    logic        unused_addr_hi;

    byte_en_gen u_byte_en_gen (
        .size     (size),
        .addr_lo  (addr[1:0]),
        .be       (req_be),
        .misalign (req_misalign)
    );

    assign req_idx        = addr[DEPTH_LOG2+1:2];
    assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];
    assign accept         = req && addr_ok;
    assign commit         = (state_q == RESP) && wr_q && !err_flag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            be_q       <= '0;
            err_flag_q <= 1'b0;
            wdata_q    <= '0;
            data_ok_q  <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q       <= wr;
                idx_q      <= req_idx;
                be_q       <= req_be;
                err_flag_q <= req_misalign;
                wdata_q    <= wdata;
            end
            data_ok_q <= (state_d == RESP);
            if (state_d == RESP) begin
                err_q <= ld_err;
                if (ld_err) begin
                    rdata_q <= '0;
                end else if (!ld_wr) begin
                    rdata_q <= fwd_word;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (req) begin
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_ok = (state_q == IDLE) || (state_q == RESP);
    end

    // The transaction entering RESP is either accepted this cycle (LATENCY=1) or the latched one.
    always_comb begin
        ld_wr  = accept ? wr           : wr_q;
        ld_err = accept ? req_misalign : err_flag_q;
        ld_idx = accept ? req_idx      : idx_q;
        for (int b = 0; b < 4; b++) begin
            if (commit && (idx_q == ld_idx) && be_q[b]) begin
                fwd_word[8*b +: 8] = wdata_q[8*b +: 8];
            end else begin
                fwd_word[8*b +: 8] = ram[ld_idx][8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    ram[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign data_ok = data_ok_q;
    assign rdata   = rdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_sram_like_resp.sv
// tb/tb_sram_like_resp.sv - self-checking bench for sram_like_resp at LATENCY=2 and LATENCY=1
module tb_sram_like_resp;

    logic        clk = 1'b0;
    logic        rst;

    logic        req2, wr2, req1, wr1;
    logic [1:0]  size2, size1;
    logic [31:0] addr2, wdata2, addr1, wdata1;
    logic        aok2, dok2, err2, aok1, dok1, err1;
    logic [31:0] rdata2, rdata1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [2][4096];
    logic [31:0] last_rd [2];
    logic [31:0] last_obs;
    logic        last_err;

    always #5 clk = ~clk;

    sram_like_resp #(.DEPTH_LOG2(12), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req(req2), .wr(wr2), .size(size2), .addr(addr2), .wdata(wdata2),
        .addr_ok(aok2), .data_ok(dok2), .rdata(rdata2), .err(err2)
    );

    sram_like_resp #(.DEPTH_LOG2(12), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req(req1), .wr(wr1), .size(size1), .addr(addr1), .wdata(wdata1),
        .addr_ok(aok1), .data_ok(dok1), .rdata(rdata1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic r, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin req1 = r; wr1 = w; size1 = s; addr1 = a; wdata1 = d; end
        else     begin req2 = r; wr2 = w; size2 = s; addr2 = a; wdata2 = d; end
    endtask

    function automatic logic g_aok(input bit sel);        return sel ? aok1   : aok2;   endfunction
    function automatic logic g_dok(input bit sel);        return sel ? dok1   : dok2;   endfunction
    function automatic logic g_err(input bit sel);        return sel ? err1   : err2;   endfunction
    function automatic logic [31:0] g_rd(input bit sel);  return sel ? rdata1 : rdata2; endfunction

    // Reference: legality and lane selection straight from the access rules, RAM as a word array.
    task automatic model(input bit sel, input bit w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, output logic e, output logic [31:0] rd);
        bit legal;
        int idx;
        bit en;
        legal = (s == 2'd0) || (s == 2'd1 && a[0] == 1'b0) || (s == 2'd2 && a[1:0] == 2'b00);
        idx   = int'((a >> 2) % 4096);
        if (!legal) begin
            e  = 1'b1;
            rd = 32'h0;
        end else if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (s == 2'd0)      en = (b == int'(a[1:0]));
                else if (s == 2'd1) en = ((b / 2) == int'(a[1]));
                else                en = 1'b1;
                if (en) mem[sel][idx][8*b +: 8] = d[8*b +: 8];
            end
            e  = 1'b0;
            rd = last_rd[sel];
        end else begin
            e  = 1'b0;
            rd = mem[sel][idx];
        end
        last_rd[sel] = rd;
    endtask

    task automatic xact(input bit sel, input bit w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d);
        int lat;
        int n;
        logic        exp_err;
        logic [31:0] exp_rd;
        lat = sel ? 1 : 2;
        model(sel, w, s, a, d, exp_err, exp_rd);
        @(negedge clk);
        chk("dok_idle", g_dok(sel), 1'b0);
        drive(sel, 1'b1, w, s, a, d);
        n = 0;
        while (g_aok(sel) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1 drive(sel, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            chk("dok_early", g_dok(sel), 1'b0);
            chk("aok_wait", g_aok(sel), 1'b0);
        end
        @(negedge clk);
        chk("dok", g_dok(sel), 1'b1);
        chk("err", g_err(sel), exp_err);
        chk("rdata", g_rd(sel), exp_rd);
        last_obs = g_rd(sel);
        last_err = g_err(sel);
    endtask

    initial begin
        logic        e_a, e_b;
        logic [31:0] r_a, r_b;
        logic [31:0] ra;

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_dok2", dok2, 1'b0);
        chk("rst_rd2", rdata2, 32'h0);
        chk("rst_err2", err2, 1'b0);
        chk("rst_aok2", aok2, 1'b1);
        chk("rst_dok1", dok1, 1'b0);
        chk("rst_aok1", aok1, 1'b1);
        rst = 1'b1;

        xact(1'b0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        chk("wr_word_err", last_err, 1'b0);
        xact(1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
        chk("rd_deadbeef", last_obs, 32'hDEADBEEF);
        xact(1'b0, 1'b1, 2'd0, 32'h11, 32'h0000AA00);
        xact(1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
        chk("rd_byte_merge", last_obs, 32'hDEADAAEF);
        xact(1'b0, 1'b1, 2'd1, 32'h12, 32'h12340000);
        xact(1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
        chk("rd_half_merge", last_obs, 32'h1234AAEF);

        xact(1'b0, 1'b0, 2'd2, 32'h12, 32'h0);
        chk("mis_word_err", last_err, 1'b1);
        chk("mis_word_rd", last_obs, 32'h0);
        xact(1'b0, 1'b1, 2'd1, 32'h11, 32'hFFFFFFFF);
        chk("mis_half_err", last_err, 1'b1);
        xact(1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
        chk("mis_half_noop", last_obs, 32'h1234AAEF);
        xact(1'b0, 1'b0, 2'd3, 32'h10, 32'h0);
        chk("size3_err", last_err, 1'b1);

        xact(1'b0, 1'b1, 2'd2, 32'h0000_4004, 32'h11111111);
        xact(1'b0, 1'b0, 2'd2, 32'h4, 32'h0);
        chk("wrap_rd", last_obs, 32'h11111111);

        // Back-to-back accepts with LATENCY=1; same-edge write must be visible to the read.
        xact(1'b1, 1'b1, 2'd2, 32'h20, 32'h0);
        model(1'b1, 1'b1, 2'd0, 32'h20, 32'h55, e_a, r_a);
        model(1'b1, 1'b0, 2'd2, 32'h20, 32'h0, e_b, r_b);
        @(negedge clk);
        chk("b2b_aok0", aok1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 32'h20, 32'h55);
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
        @(negedge clk);
        chk("b2b_dok_w", dok1, 1'b1);
        chk("b2b_aok_resp", aok1, 1'b1);
        chk("b2b_err_w", err1, e_a);
        chk("b2b_rd_w", rdata1, r_a);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b_dok_r", dok1, 1'b1);
        chk("b2b_err_r", err1, e_b);
        chk("b2b_rd_model", rdata1, r_b);
        chk("b2b_rd_55", rdata1, 32'h00000055);
        @(negedge clk);
        chk("b2b_dok_end", dok1, 1'b0);

        // Reset while a write is pending: no response and no commit.
        xact(1'b0, 1'b1, 2'd2, 32'h30, 32'h0BADF00D);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h30, 32'hFFFFFFFF);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_dok", dok2, 1'b0);
        chk("mid_rst_rd", rdata2, 32'h0);
        chk("mid_rst_err", err2, 1'b0);
        chk("mid_rst_aok", aok2, 1'b1);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_dok", dok2, 1'b0);
        end
        xact(1'b0, 1'b0, 2'd2, 32'h30, 32'h0);
        chk("post_rst_rd", last_obs, 32'h0BADF00D);

        // Randomized traffic over a small index window with random ignored high address bits.
        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < 16; i++) begin
                xact(sel[0], 1'b1, 2'd2, 32'(i * 4), $urandom);
            end
            for (int i = 0; i < 40; i++) begin
                ra = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
                xact(sel[0], 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_like_resp.md
Name: sram_like_resp

Overview:
- Memory-side responder for the CPU's SRAM-like data-access port.
- Accepts one request at a time (read or write, byte/half/word) and holds it for a programmable latency.
- Commits writes with byte enables, or returns the aligned read word, with a one-cycle data_ok pulse.
- Sits between the datapath's aluoutM/writedataM/readdataM side and a local word-addressed RAM. Serves as the memory model for datapath and stall bring-up and as the FPGA data RAM.

Parameters:
- DEPTH_LOG2, 12: RAM depth is 2**DEPTH_LOG2 32-bit words.
- LATENCY, 2: number of cycles from the accept cycle to the data_ok cycle. Legal range is 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset: asserted at 0, released at 1.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- addr  in  32  byte address.
- wdata  in  32  write data, already placed in its byte lanes by the requester.
- addr_ok  out  1  request accepted this cycle when req && addr_ok.
- data_ok  out  1  one-cycle response pulse.
- rdata  out  32  full aligned word for reads. Not shifted, not sign-extended.
- err  out  1  valid with data_ok; 1 = misaligned or reserved size.

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - state=IDLE, data_ok=0, rdata=0, err=0, counter=0.
  - Any pending request is dropped with no write commit.
  - RAM contents are not reset.
- States:
  - IDLE: addr_ok=1. On req: latch wr, word index addr[DEPTH_LOG2+1:2], byte enables, err_flag and wdata. Go to WAIT with cnt=LATENCY-1; if LATENCY=1, go straight to RESP.
  - WAIT: addr_ok=0. Decrement cnt; when cnt reaches 1, next state is RESP.
  - RESP: data_ok=1 and addr_ok=1.
    - A new req in this cycle is accepted and goes to WAIT/RESP as from IDLE; otherwise go to IDLE.
    - This allows back-to-back accepts.
- data_ok, rdata and err are registered outputs:
  - Accept in cycle T gives data_ok high in cycle T+LATENCY only.
  - data_ok is never high for two consecutive cycles unless a request was accepted in the preceding RESP cycle and LATENCY=1.
- Read:
  - rdata = RAM[index] as sampled for the data_ok cycle.
  - rdata holds its value until the next data_ok.
  - Writes never update rdata.
- Write:
  - Enabled bytes of wdata are written at the clock edge ending the data_ok cycle.
  - A read accepted in that same RESP cycle observes the new data.
- Byte enables (addr[1:0] = a):
  - Byte: lane a.
  - Half: lanes {a+1,a}; legal only when a[0]=0.
  - Word: all four lanes; legal only when a=0.
  - size=3 is illegal.
- Illegal request:
  - Still completes with normal timing, with err=1 and rdata=0.
  - No write is committed.
  - Error responses leave RAM unchanged.
- Address bits above DEPTH_LOG2+1 are ignored; the index wraps.
- addr_ok is combinational from state only; it never depends on req.
- req while addr_ok=0 is ignored; the requester must hold req until accepted.

Decomposition:
- Package mem_pkg holds:
  - SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2.
  - State encoding IDLE/WAIT/RESP (2 bits).
  - Maximum LATENCY constant for the counter width (4 bits).
- Sub-module byte_en_gen is combinational:
  - Inputs size and addr[1:0].
  - Outputs be[3:0] and misalign.
  - Reused later by the store path.
- RAM is an inferred array inside sram_like_resp with a synchronous byte-enable write.

Test Plan:
- LATENCY=2, reset, write word 0xDEADBEEF at addr 0x10 accepted at T -> data_ok only at T+2, err=0. Read of 0x10 -> rdata=0xDEADBEEF, data_ok two cycles after its accept, addr_ok low in between.
- Byte write 0xAA at 0x11 with wdata=0x0000AA00, then word read of 0x10 -> rdata=0xDEADAAEF. Half write 0x1234 at 0x12 with wdata=0x12340000 -> read gives 0x1234AAEF.
- Misaligned requests:
  - Word read at 0x12 -> data_ok at T+2 with err=1, rdata=0.
  - Half write at 0x11 -> err=1, and a later read of 0x10 is unchanged (0x1234AAEF).
  - size=3 -> err=1.
- Back-to-back, LATENCY=1:
  - req held high for a write of 0x55 to 0x20 followed by a read of 0x20 -> accepts in consecutive cycles and data_ok high two consecutive cycles.
  - The read returns 0x00000055 (same-edge write visible).
- Reset mid-operation: write 0xFFFFFFFF to 0x30 accepted, rst=0 one cycle later, then released -> no data_ok, outputs 0, addr_ok=1. Read of 0x30 returns its prior value.
- Wrap-around: write 0x11111111 to word index 1 with an addr bit above DEPTH_LOG2+1 set, then read addr 0x4 -> rdata=0x11111111.
